// File: rtl/he_pkg.sv
// Shared definitions for the histogram-equalization sequencer and datapath:
// phase encodings and default frame/bin geometry.
package he_pkg;

    localparam int NUM_PIXELS_DEF = 262144;
    localparam int HIST_BINS_DEF  = 256;
    localparam int CNT_W_DEF      = 19;
    localparam int BIN_W_DEF      = 8;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_CLEAR = 3'd1,
        PH_ACCUM = 3'd2,
        PH_CDF   = 3'd3,
        PH_LUT   = 3'd4,
        PH_MAP   = 3'd5,
        PH_DRAIN = 3'd6,
        PH_DONE  = 3'd7
    } he_phase_t;

endpackage

// File: rtl/he_stream_stage.sv
// One-deep valid/ready register holding the mapped pixel at the mapper output.
module he_stream_stage (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic load,
    input  logic out_ready,
    output logic out_valid,
    output logic ready
);

    logic valid_r;

    // Valid flag: load wins over drain so a back-to-back transfer keeps it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= 1'b0;
        end else if (clr) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign out_valid = valid_r;
    assign ready     = !valid_r | out_ready;

endmodule

// File: rtl/he_phase_sequencer.sv
// Frame controller for histogram equalization: clear, accumulate, CDF walk,
// LUT walk and map pass, with per-phase strobes and pixel handshakes.
module he_phase_sequencer
    import he_pkg::*;
#(
    parameter int NUM_PIXELS = NUM_PIXELS_DEF,
    parameter int HIST_BINS  = HIST_BINS_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int BIN_W      = BIN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             hist_nz,
    output logic [BIN_W-1:0] bin_addr,
    output logic             hist_clr,
    output logic             hist_inc,
    output logic             cdf_we,
    output logic             cdf_min_cap,
    output logic             lut_we,
    output logic             map_en,
    output logic             busy,
    output logic             done,
    output logic [2:0]       phase
);

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(HIST_BINS - 1);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIXELS - 1);

    he_phase_t        state_r;
    he_phase_t        state_nxt_s;
    logic [CNT_W-1:0] pix_cnt_r;
    logic [BIN_W-1:0] bin_cnt_r;
    logic             found_r;
    logic             stage_ready_s;
    logic             stage_clr_s;
    logic             abort_s;
    logic             last_bin_s;
    logic             last_pix_s;

    assign abort_s     = abort & (state_r != PH_IDLE);
    assign last_bin_s  = (bin_cnt_r == LAST_BIN);
    assign last_pix_s  = (pix_cnt_r == LAST_PIX);
    assign stage_clr_s = abort_s | ((state_r != PH_MAP) & (state_r != PH_DRAIN));

    he_stream_stage u_stage (
        .clk       (clk),
        .reset     (reset),
        .clr       (stage_clr_s),
        .load      (map_en),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .ready     (stage_ready_s)
    );

    // Per-phase strobes, bin address and input handshake decoded from state.
    always_comb begin
        hist_clr    = 1'b0;
        hist_inc    = 1'b0;
        cdf_we      = 1'b0;
        cdf_min_cap = 1'b0;
        lut_we      = 1'b0;
        map_en      = 1'b0;
        in_ready    = 1'b0;
        bin_addr    = {BIN_W{1'b0}};
        case (state_r)
            PH_CLEAR: begin
                hist_clr = 1'b1;
                bin_addr = bin_cnt_r;
            end
            PH_ACCUM: begin
                in_ready = 1'b1;
                hist_inc = in_valid;
            end
            PH_CDF: begin
                cdf_we      = 1'b1;
                bin_addr    = bin_cnt_r;
                cdf_min_cap = hist_nz & !found_r;
            end
            PH_LUT: begin
                lut_we   = 1'b1;
                bin_addr = bin_cnt_r;
            end
            PH_MAP: begin
                in_ready = stage_ready_s;
                map_en   = in_valid & stage_ready_s;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Next-state selection; abort overrides every other transition.
    always_comb begin
        state_nxt_s = state_r;
        if (abort_s) begin
            state_nxt_s = PH_IDLE;
        end else begin
            case (state_r)
                PH_IDLE:  state_nxt_s = start ? PH_CLEAR : PH_IDLE;
                PH_CLEAR: state_nxt_s = last_bin_s ? PH_ACCUM : PH_CLEAR;
                PH_ACCUM: state_nxt_s = (in_valid & last_pix_s) ? PH_CDF : PH_ACCUM;
                PH_CDF:   state_nxt_s = last_bin_s ? PH_LUT : PH_CDF;
                PH_LUT:   state_nxt_s = last_bin_s ? PH_MAP : PH_LUT;
                PH_MAP:   state_nxt_s = (map_en & last_pix_s) ? PH_DRAIN : PH_MAP;
                PH_DRAIN: state_nxt_s = (!out_valid | out_ready) ? PH_DONE : PH_DRAIN;
                PH_DONE:  state_nxt_s = PH_IDLE;
                default:  state_nxt_s = PH_IDLE;
            endcase
        end
    end

    // State, pixel/bin counters and the sticky first-nonzero-bin flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= PH_IDLE;
            pix_cnt_r <= {CNT_W{1'b0}};
            bin_cnt_r <= {BIN_W{1'b0}};
            found_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (abort_s) begin
                pix_cnt_r <= {CNT_W{1'b0}};
                bin_cnt_r <= {BIN_W{1'b0}};
                found_r   <= 1'b0;
            end else begin
                case (state_r)
                    PH_IDLE: begin
                        if (start) begin
                            pix_cnt_r <= {CNT_W{1'b0}};
                            bin_cnt_r <= {BIN_W{1'b0}};
                            found_r   <= 1'b0;
                        end
                    end
                    PH_CLEAR, PH_LUT: begin
                        // bin_cnt wraps to zero exactly as the walk exits
                        bin_cnt_r <= bin_cnt_r + BIN_W'(1);
                        if (last_bin_s) begin
                            pix_cnt_r <= {CNT_W{1'b0}};
                        end
                    end
                    PH_ACCUM: begin
                        if (in_valid) begin
                            pix_cnt_r <= last_pix_s ? {CNT_W{1'b0}} : pix_cnt_r + CNT_W'(1);
                        end
                    end
                    PH_CDF: begin
                        bin_cnt_r <= bin_cnt_r + BIN_W'(1);
                        if (cdf_min_cap) begin
                            found_r <= 1'b1;
                        end
                    end
                    PH_MAP: begin
                        if (map_en) begin
                            pix_cnt_r <= last_pix_s ? {CNT_W{1'b0}} : pix_cnt_r + CNT_W'(1);
                        end
                    end
                    default: begin
                        pix_cnt_r <= pix_cnt_r;
                    end
                endcase
            end
        end
    end

    assign busy  = (state_r != PH_IDLE);
    assign done  = (state_r == PH_DONE);
    assign phase = state_r;

endmodule

// File: tb/tb_he_phase_sequencer.sv
// Directed bench for he_phase_sequencer with a 16-pixel, 4-bin frame.
module tb_he_phase_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, abort, in_valid, out_ready, hist_nz;
    logic       in_ready, out_valid, hist_clr, hist_inc, cdf_we, cdf_min_cap;
    logic       lut_we, map_en, busy, done;
    logic [1:0] bin_addr;
    logic [2:0] phase;

    int n_cmp = 0;
    int n_bad = 0;

    int r_clr, r_inc, r_cdf, r_lut, r_map, r_done, r_busy, r_done_cyc, r_xfer;
    int r_excl, r_cap, r_cap_bin, r_stall_cyc, r_stall_bad, r_last_inc;
    int r_first_cdf, r_abort_phase, r_end_phase;
    bit r_timeout;

    he_phase_sequencer #(.NUM_PIXELS(16), .HIST_BINS(4), .CNT_W(5), .BIN_W(2)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .hist_nz(hist_nz), .bin_addr(bin_addr),
        .hist_clr(hist_clr), .hist_inc(hist_inc), .cdf_we(cdf_we),
        .cdf_min_cap(cdf_min_cap), .lut_we(lut_we), .map_en(map_en),
        .busy(busy), .done(done), .phase(phase)
    );

    always #5 clk = ~clk;

    // Runs one frame from a start pulse; cycle 1 is the first CLEAR cycle.
    task automatic run_frame(input int stall_at, input bit gaps, input logic [3:0] nz,
                             input int abort_bin, input bit restart);
        int stall_rem = 0;
        bit stalled   = 1'b0;
        bit abort_prev = 1'b0;
        r_clr = 0; r_inc = 0; r_cdf = 0; r_lut = 0; r_map = 0; r_done = 0;
        r_busy = 0; r_done_cyc = -1; r_xfer = 0; r_excl = 0; r_cap = 0;
        r_cap_bin = -1; r_stall_cyc = 0; r_stall_bad = 0; r_last_inc = -1;
        r_first_cdf = -1; r_abort_phase = -1; r_end_phase = -1; r_timeout = 1'b1;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            in_valid = (gaps && phase == 3'd2) ? c[0] : 1'b1;
            hist_nz  = (phase == 3'd3) ? nz[bin_addr] : 1'b0;
            start    = (restart && phase == 3'd1 && c <= 3) ? 1'b1 : 1'b0;
            if (stall_at >= 0 && !stalled && phase == 3'd5 && r_map == stall_at) begin
                stalled   = 1'b1;
                stall_rem = 5;
            end
            out_ready = (stall_rem == 0);
            abort     = (abort_bin >= 0 && phase == 3'd3 && int'(bin_addr) == abort_bin);
            #1;
            if (abort_prev) r_abort_phase = int'(phase);
            if (hist_clr) r_clr++;
            if (hist_inc) begin r_inc++; r_last_inc = c; end
            if (cdf_we) begin r_cdf++; if (r_first_cdf < 0) r_first_cdf = c; end
            if (lut_we) r_lut++;
            if (map_en) r_map++;
            if (cdf_min_cap) begin r_cap++; r_cap_bin = int'(bin_addr); end
            if (done) begin r_done++; r_done_cyc = c; end
            if (busy) r_busy++;
            if (out_valid && out_ready) r_xfer++;
            if (int'(hist_clr) + int'(hist_inc) + int'(cdf_we) + int'(lut_we) + int'(map_en) > 1)
                r_excl++;
            if (stall_rem > 0) begin
                r_stall_cyc++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || map_en !== 1'b0) r_stall_bad++;
                stall_rem--;
            end
            abort_prev = abort;
            if (!busy) begin
                r_end_phase = int'(phase);
                r_timeout   = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        abort = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; hist_nz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid, hist_clr, hist_inc, cdf_we, cdf_min_cap, lut_we,
             map_en, busy, done} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 0", {in_ready, out_valid, hist_clr,
                     hist_inc, cdf_we, cdf_min_cap, lut_we, map_en, busy, done});
        end
        n_cmp++;
        if (phase !== 3'd0 || bin_addr !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_phase: got phase %0d addr %0d want 0 0", phase, bin_addr);
        end
        reset = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    endtask

    task automatic test_clean_frame();
        run_frame(-1, 1'b0, 4'b1111, -1, 1'b0);
        n_cmp++; if (r_timeout) begin n_bad++; $display("FAIL clean_timeout: frame did not end"); end
        n_cmp++; if (r_clr != 4)  begin n_bad++; $display("FAIL clean_hist_clr: got %0d want 4", r_clr); end
        n_cmp++; if (r_inc != 16) begin n_bad++; $display("FAIL clean_hist_inc: got %0d want 16", r_inc); end
        n_cmp++; if (r_cdf != 4)  begin n_bad++; $display("FAIL clean_cdf_we: got %0d want 4", r_cdf); end
        n_cmp++; if (r_lut != 4)  begin n_bad++; $display("FAIL clean_lut_we: got %0d want 4", r_lut); end
        n_cmp++; if (r_map != 16) begin n_bad++; $display("FAIL clean_map_en: got %0d want 16", r_map); end
        n_cmp++; if (r_xfer != 16) begin n_bad++; $display("FAIL clean_outputs: got %0d want 16", r_xfer); end
        n_cmp++; if (r_done != 1 || r_done_cyc != 46) begin
            n_bad++; $display("FAIL clean_done: got %0d pulses at cycle %0d want 1 at 46", r_done, r_done_cyc);
        end
        n_cmp++; if (r_busy != 46) begin n_bad++; $display("FAIL clean_frame_len: got %0d want 46", r_busy); end
        n_cmp++; if (r_end_phase != 0) begin n_bad++; $display("FAIL clean_end_phase: got %0d want 0", r_end_phase); end
        n_cmp++; if (r_excl != 0) begin n_bad++; $display("FAIL clean_exclusive: got %0d overlaps want 0", r_excl); end
        n_cmp++; if (r_cap != 1 || r_cap_bin != 0) begin
            n_bad++; $display("FAIL clean_cap: got %0d at bin %0d want 1 at 0", r_cap, r_cap_bin);
        end
    endtask

    task automatic test_cdf_min();
        run_frame(-1, 1'b0, 4'b1100, -1, 1'b0);
        n_cmp++; if (r_cap != 1 || r_cap_bin != 2) begin
            n_bad++; $display("FAIL cdfmin_0011: got %0d at bin %0d want 1 at 2", r_cap, r_cap_bin);
        end
        run_frame(-1, 1'b0, 4'b0000, -1, 1'b0);
        n_cmp++; if (r_cap != 0) begin n_bad++; $display("FAIL cdfmin_none: got %0d want 0", r_cap); end
        n_cmp++; if (r_done != 1) begin n_bad++; $display("FAIL cdfmin_done: got %0d want 1", r_done); end
    endtask

    task automatic test_backpressure();
        run_frame(8, 1'b0, 4'b1111, -1, 1'b0);
        n_cmp++; if (r_stall_cyc != 5 || r_stall_bad != 0) begin
            n_bad++; $display("FAIL bp_hold: got %0d stall cycles %0d bad want 5 0", r_stall_cyc, r_stall_bad);
        end
        n_cmp++; if (r_map != 16 || r_xfer != 16) begin
            n_bad++; $display("FAIL bp_count: got map %0d out %0d want 16 16", r_map, r_xfer);
        end
        n_cmp++; if (r_busy != 51) begin n_bad++; $display("FAIL bp_frame_len: got %0d want 51", r_busy); end
    endtask

    task automatic test_input_gaps();
        run_frame(-1, 1'b1, 4'b1111, -1, 1'b0);
        n_cmp++; if (r_inc != 16) begin n_bad++; $display("FAIL gaps_hist_inc: got %0d want 16", r_inc); end
        n_cmp++; if (r_last_inc != 35 || r_first_cdf != 36) begin
            n_bad++; $display("FAIL gaps_to_cdf: got last inc %0d first cdf %0d want 35 36", r_last_inc, r_first_cdf);
        end
        n_cmp++; if (r_busy != 61) begin n_bad++; $display("FAIL gaps_frame_len: got %0d want 61", r_busy); end
    endtask

    task automatic test_abort();
        run_frame(-1, 1'b0, 4'b1111, 1, 1'b0);
        n_cmp++; if (r_abort_phase != 0 || r_busy != 22) begin
            n_bad++; $display("FAIL abort_idle: got phase %0d busy %0d want 0 22", r_abort_phase, r_busy);
        end
        n_cmp++; if (r_done != 0) begin n_bad++; $display("FAIL abort_done: got %0d want 0", r_done); end
        run_frame(-1, 1'b0, 4'b1111, -1, 1'b0);
        n_cmp++; if (r_done != 1 || r_busy != 46 || r_map != 16) begin
            n_bad++; $display("FAIL abort_rerun: got done %0d busy %0d map %0d want 1 46 16", r_done, r_busy, r_map);
        end
    endtask

    task automatic test_reset_mid_map();
        bit seen = 1'b0;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (phase == 3'd5 && out_valid) begin seen = 1'b1; break; end
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL rst_reach_map: got no MAP with out_valid"); end
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || phase !== 3'd0) begin
            n_bad++; $display("FAIL rst_async: got valid %b ready %b busy %b phase %0d want 0 0 0 0",
                              out_valid, in_ready, busy, phase);
        end
        @(posedge clk); #1; reset = 1'b0;
        run_frame(-1, 1'b0, 4'b1111, -1, 1'b1);
        n_cmp++; if (r_clr != 4 || r_busy != 46 || r_done != 1) begin
            n_bad++; $display("FAIL rst_restart_ignored: got clr %0d busy %0d done %0d want 4 46 1", r_clr, r_busy, r_done);
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_cdf_min();
        test_backpressure();
        test_input_gaps();
        test_abort();
        test_reset_mid_map();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
